// File: rtl/fp_pkg.sv
// Shared FP32/INT32 constants and the converter state type.
package fp_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned SIGN_POS = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;

  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

  localparam logic [31:0] INT32_MAX   = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN   = 32'h8000_0000;
  localparam logic [31:0] FP_NEG_2P31 = 32'hCF00_0000;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    SHIFT,
    FINISH
  } state_t;

endpackage

// File: rtl/negate_32bit.sv
// Combinational two's-complement negation.
module negate_32bit (
  input  logic [31:0] in,
  output logic [31:0] out
);

  assign out = ~in + 32'd1;

endmodule

// File: rtl/fp32_to_int_seq.sv
// Sequential FP32 -> INT32 converter: truncating, saturating, one shift per cycle.
module fp32_to_int_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fp_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] int_out,
  output logic        overflow,
  output logic        invalid
);

  state_t state, state_nxt;

  logic [FP_W-1:0]   op_q;
  logic [31:0]       mag_q;
  logic              sign_q;
  logic              left_q;
  logic              sat_q;
  logic              ovf_q;
  logic              inv_q;
  logic [4:0]        cnt_q;

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;
  logic signed [8:0] e_unb;

  logic [31:0]       dec_mag;
  logic              dec_sat;
  logic              dec_ovf;
  logic              dec_inv;
  logic              dec_left;
  logic [4:0]        dec_k;

  logic [31:0]       neg_mag;

  assign exp_f  = op_q[EXP_MSB:EXP_LSB];
  assign mant_f = op_q[MANT_W-1:0];
  assign e_unb  = $signed({1'b0, exp_f}) - $signed({1'b0, EXP_BIAS});

  // dec_sat marks results that are already final and bypass sign application.
  always_comb begin
    dec_mag  = {8'b0, 1'b1, mant_f};
    dec_sat  = 1'b0;
    dec_ovf  = 1'b0;
    dec_inv  = 1'b0;
    dec_left = 1'b0;
    dec_k    = '0;
    if (exp_f == EXP_ALL1) begin
      dec_sat = 1'b1;
      if (mant_f != '0) begin
        dec_mag = INT32_MIN;
        dec_inv = 1'b1;
      end else begin
        dec_mag = op_q[SIGN_POS] ? INT32_MIN : INT32_MAX;
        dec_ovf = 1'b1;
      end
    end else if (e_unb < 9'sd0) begin
      dec_mag = '0;
      dec_sat = 1'b1;
    end else if (e_unb > 9'sd30) begin
      dec_sat = 1'b1;
      if (op_q == FP_NEG_2P31) begin
        dec_mag = INT32_MIN;
      end else begin
        dec_mag = op_q[SIGN_POS] ? INT32_MIN : INT32_MAX;
        dec_ovf = 1'b1;
      end
    end else if (e_unb > 9'sd22) begin
      // E is 0..30 here, so 5-bit modular differences are exact.
      dec_left = 1'b1;
      dec_k    = e_unb[4:0] - 5'd23;
    end else begin
      dec_k    = 5'd23 - e_unb[4:0];
    end
  end

  negate_32bit u_negate (
    .in  (mag_q),
    .out (neg_mag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DECODE;
      DECODE:  state_nxt = (dec_k != '0) ? SHIFT : FINISH;
      SHIFT:   if (cnt_q == 5'd1) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      left_q   <= 1'b0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      int_out  <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= fp_in;
            busy <= 1'b1;
          end
        end
        DECODE: begin
          mag_q  <= dec_mag;
          sign_q <= op_q[SIGN_POS];
          left_q <= dec_left;
          sat_q  <= dec_sat;
          ovf_q  <= dec_ovf;
          inv_q  <= dec_inv;
          cnt_q  <= dec_k;
        end
        SHIFT: begin
          mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
          cnt_q <= cnt_q - 5'd1;
        end
        FINISH: begin
          int_out  <= (sat_q || !sign_q) ? mag_q : neg_mag;
          overflow <= ovf_q;
          invalid  <= inv_q;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// Directed table, protocol sequences and random operands checked against a real-arithmetic model.
module tb_fp32_to_int_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] fp_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] int_out;
  logic        overflow;
  logic        invalid;

  int n_cmp = 0;
  int n_bad = 0;

  fp32_to_int_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .fp_in    (fp_in),
    .busy     (busy),
    .done     (done),
    .int_out  (int_out),
    .overflow (overflow),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fp;
    logic [31:0] res;
    logic        ov;
    logic        iv;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Reference: exact real-valued interpretation, truncated toward zero.
  function automatic void model(input logic [31:0] x, output logic [31:0] r,
                                output logic ov, output logic iv, output int lat);
    int  e;
    real v;
    e   = int'(x[30:23]) - 127;
    ov  = 1'b0;
    iv  = 1'b0;
    lat = 2;
    r   = '0;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != '0) begin
        r  = 32'h8000_0000;
        iv = 1'b1;
      end else begin
        r  = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        ov = 1'b1;
      end
    end else if (x[30:23] != 8'h00) begin
      v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** e);
      if (x[31]) v = -v;
      if (v >= 2147483648.0) begin
        r  = 32'h7FFF_FFFF;
        ov = 1'b1;
      end else if (v < -2147483648.0) begin
        r  = 32'h8000_0000;
        ov = 1'b1;
      end else begin
        r = 32'($rtoi(v));
      end
      if (e >= 0 && e <= 30) lat = 2 + ((e >= 23) ? (e - 23) : (23 - e));
    end
  endfunction

  // Issue one operand, optionally pulse start again while busy, wait for done.
  task automatic convert(input logic [31:0] x, input int inj, output logic [31:0] r,
                         output logic ov, output logic iv, output int lat);
    @(negedge clk);
    fp_in = x;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == inj) begin
        start = 1'b1;
        fp_in = 32'h7FC0_0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("busy_at_done", 32'(busy), 32'd0);
    r  = int_out;
    ov = overflow;
    iv = invalid;
  endtask

  task automatic check_conv(input string nm, input logic [31:0] x, input logic [31:0] res,
                            input logic ov_w, input logic iv_w, input int lat_w, input int inj);
    logic [31:0] r;
    logic        ov, iv;
    int          lat;
    convert(x, inj, r, ov, iv, lat);
    chk({nm, "_int"}, r, res);
    chk({nm, "_ovf"}, 32'(ov), 32'(ov_w));
    chk({nm, "_inv"}, 32'(iv), 32'(iv_w));
    chk({nm, "_lat"}, 32'(lat), 32'(lat_w));
  endtask

  task automatic no_done_for(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] x, r_m;
    logic        ov_m, iv_m;
    int          lat_m;

    tbl[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25};
    tbl[1]  = '{32'hC0B8_0000, 32'hFFFF_FFFB, 1'b0, 1'b0, 23};
    tbl[2]  = '{32'h4E80_0000, 32'h4000_0000, 1'b0, 1'b0, 9};
    tbl[3]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 2};
    tbl[4]  = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
    tbl[5]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
    tbl[6]  = '{32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 2};
    tbl[7]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2};
    tbl[8]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
    tbl[9]  = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 2};
    tbl[10] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9};
    tbl[11] = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2};
    tbl[12] = '{32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 19};
    tbl[13] = '{32'h8000_0001, 32'h0000_0000, 1'b0, 1'b0, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, overflow, invalid, int_out[27:0]}, '0);
    chk("reset_int_hi", {28'd0, int_out[31:28]}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Entries 2 and 3 run back-to-back: the second start lands in the done cycle.
    for (int i = 0; i < 14; i++)
      check_conv($sformatf("vec%0d", i), tbl[i].fp, tbl[i].res, tbl[i].ov, tbl[i].iv,
                 tbl[i].lat, -1);

    check_conv("start_while_busy", 32'hC0B8_0000, 32'hFFFF_FFFB, 1'b0, 1'b0, 23, 3);
    no_done_for("no_extra_done", 30);

    @(negedge clk);
    fp_in = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {busy, done, overflow, invalid, int_out[27:0]}, '0);
    chk("rst_mid_int_hi", {28'd0, int_out[31:28]}, '0);
    @(negedge clk);
    rst = 1'b0;
    no_done_for("no_done_after_rst", 30);
    check_conv("after_rst", 32'hC0B8_0000, 32'hFFFF_FFFB, 1'b0, 1'b0, 23, -1);

    for (int i = 0; i < 150; i++) begin
      x = $urandom;
      if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(110, 160));
      model(x, r_m, ov_m, iv_m, lat_m);
      check_conv($sformatf("rand_%h", x), x, r_m, ov_m, iv_m, lat_m, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
